// File: rtl/pwm_decodificador.sv
// -----------------------------------------------------------------------------
// pwm_decodificador
//   Receiving end of a PWM link. Samples the asynchronous pwm_in line,
//   measures the high time and the rise-to-rise period in clk cycles, and
//   publishes one (ciclo, periodo) pair per complete PWM period. A line with
//   no rising edge for 2**W-1 cycles (stuck at 0 or at 1) is flagged through
//   sin_senal.
//
// Parameters
//   W     width of the measurement counters (max measurable period 2**W-1)
//   SYNC  number of synchronizer flops on pwm_in (2 or 3)
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous reset, active low
//   pwm_in     asynchronous PWM input
//   ciclo      high time of the last complete period
//   periodo    rise-to-rise length of the last complete period
//   valido     one-cycle pulse when ciclo/periodo are updated
//   sin_senal  level, 1 = no rising edge seen for 2**W-1 cycles
// -----------------------------------------------------------------------------
module pwm_decodificador #(
  parameter int W    = 16,
  parameter int SYNC = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pwm_in,
  output logic [W-1:0] ciclo,
  output logic [W-1:0] periodo,
  output logic         valido,
  output logic         sin_senal
);

  localparam logic [W-1:0] MAX = {W{1'b1}};
  localparam logic [W-1:0] UNO = {{(W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ESPERA = 2'd0,
    ALTO   = 2'd1,
    BAJO   = 2'd2
  } estado_t;

  estado_t        estado;
  estado_t        estado_n;
  logic [SYNC-1:0] sync_p0;
  logic           hist_p1;
  logic           s;
  logic           sube;
  logic           baja;
  logic           satura;
  logic [W-1:0]   cnt_per;
  logic [W-1:0]   cnt_alto;
  logic [W-1:0]   alto_tmp;
  logic [W-1:0]   alto_n;
  logic [W-1:0]   ciclo_n;
  logic [W-1:0]   periodo_n;
  logic           valido_n;
  logic           sin_n;

  // Counter increment that sticks at the all-ones value.
  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (v == MAX) ? v : v + UNO;
  endfunction

  // Stage p0: synchronizer chain; stage p1: edge-history flop.
  // Both edges see the same latency, so measured widths are unaffected.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= '0;
      hist_p1 <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[SYNC-2:0], pwm_in};
      hist_p1 <= s;
    end
  end

  assign s    = sync_p0[SYNC-1];
  assign sube = s & ~hist_p1;
  assign baja = ~s & hist_p1;

  // A rise arriving in the same cycle as saturation is a valid period of
  // exactly 2**W-1 cycles, so it takes precedence over the dead-line flag.
  assign satura = (cnt_per == MAX) && !sube;

  // Measurement counters: both restart at 1 on every rise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_per  <= '0;
      cnt_alto <= '0;
    end else begin
      if (sube) begin
        cnt_per  <= UNO;
        cnt_alto <= UNO;
      end else begin
        cnt_per <= sat_inc(cnt_per);
        if (estado == ALTO) begin
          cnt_alto <= sat_inc(cnt_alto);
        end
      end
    end
  end

  always_comb begin
    estado_n  = estado;
    alto_n    = alto_tmp;
    ciclo_n   = ciclo;
    periodo_n = periodo;
    valido_n  = 1'b0;
    sin_n     = sin_senal;
    if (satura) begin
      // Dead or stuck line: drop back to waiting for a fresh first rise;
      // the last published pair stays visible.
      sin_n    = 1'b1;
      estado_n = ESPERA;
    end else begin
      case (estado)
        ESPERA: begin
          // First rise only arms the measurement; a fall here is ignored.
          if (sube) estado_n = ALTO;
        end
        ALTO: begin
          if (baja) begin
            alto_n   = cnt_alto;
            estado_n = BAJO;
          end
        end
        BAJO: begin
          if (sube) begin
            ciclo_n   = alto_tmp;
            periodo_n = cnt_per;
            valido_n  = 1'b1;
            sin_n     = 1'b0;
            estado_n  = ALTO;
          end
        end
        default: estado_n = ESPERA;
      endcase
    end
  end

  // Stage p2: FSM state and published results.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado    <= ESPERA;
      alto_tmp  <= '0;
      ciclo     <= '0;
      periodo   <= '0;
      valido    <= 1'b0;
      sin_senal <= 1'b0;
    end else begin
      estado    <= estado_n;
      alto_tmp  <= alto_n;
      ciclo     <= ciclo_n;
      periodo   <= periodo_n;
      valido    <= valido_n;
      sin_senal <= sin_n;
    end
  end

endmodule

// File: tb/tb_pwm_decodificador.sv
// -----------------------------------------------------------------------------
// tb_pwm_decodificador
//   Drives one pwm_in line into two decoders (W=16/SYNC=2 and W=8/SYNC=3) and
//   compares every cycle against an event-based reference model: rises and
//   falls are recorded as sample times, publications are scheduled from the
//   rise-to-rise and rise-to-fall distances, and the dead-line flag follows
//   from the distance to the most recent rise.
// -----------------------------------------------------------------------------
module tb_pwm_decodificador;

  logic        clk    = 1'b0;
  logic        reset  = 1'b0;
  logic        pwm_in = 1'b0;
  logic [15:0] ciclo16;
  logic [15:0] periodo16;
  logic        valido16;
  logic        sin16;
  logic [7:0]  ciclo8;
  logic [7:0]  periodo8;
  logic        valido8;
  logic        sin8;

  always #5 clk = ~clk;

  pwm_decodificador #(.W(16), .SYNC(2)) dut16 (
    .clk(clk), .reset(reset), .pwm_in(pwm_in),
    .ciclo(ciclo16), .periodo(periodo16), .valido(valido16), .sin_senal(sin16)
  );

  pwm_decodificador #(.W(8), .SYNC(3)) dut8 (
    .clk(clk), .reset(reset), .pwm_in(pwm_in),
    .ciclo(ciclo8), .periodo(periodo8), .valido(valido8), .sin_senal(sin8)
  );

  logic        o_v [2];
  logic        o_s [2];
  logic [15:0] o_c [2];
  logic [15:0] o_p [2];
  assign o_v[0] = valido16;
  assign o_v[1] = valido8;
  assign o_s[0] = sin16;
  assign o_s[1] = sin8;
  assign o_c[0] = ciclo16;
  assign o_c[1] = {8'h00, ciclo8};
  assign o_p[0] = periodo16;
  assign o_p[1] = {8'h00, periodo8};

  int vectors     = 0;
  int miscompares = 0;
  int ecount      = 0;
  always @(posedge clk) ecount <= ecount + 1;

  // ---------------- reference model ----------------
  typedef struct packed { int t; int c; int p; } ev_t;

  ev_t  evq [2][$];
  int   rq  [2][$];
  logic in_rst = 1'b1;
  logic prev   = 1'b0;
  logic armed [2];
  logic fell  [2];
  int   last_rise [2];
  int   last_fall [2];
  logic e_v [2];
  logic e_s [2];
  int   e_c [2];
  int   e_p [2];

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : 3;
  endfunction

  function automatic int max_of(input int i);
    return (i == 0) ? 65535 : 255;
  endfunction

  // Record the level that the DUT will sample at edge k.
  task automatic model_drive(input logic lvl, input logic rst_lvl, input int k);
    if (!rst_lvl) begin
      in_rst = 1'b1;
      prev   = 1'b0;
      return;
    end
    if (in_rst) begin
      in_rst = 1'b0;
      prev   = 1'b0;
      for (int i = 0; i < 2; i++) begin
        evq[i].delete();
        rq[i].delete();
        // Counters restart from 0 at release: equivalent to a rise that
        // never arms the measurement.
        rq[i].push_back(k - lat_of(i));
        armed[i] = 1'b0;
        fell[i]  = 1'b0;
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (lvl && !prev) begin
        if (armed[i] && fell[i] && (k - last_rise[i]) <= max_of(i))
          evq[i].push_back('{k + lat_of(i), last_fall[i] - last_rise[i], k - last_rise[i]});
        armed[i]     = 1'b1;
        fell[i]      = 1'b0;
        last_rise[i] = k;
        rq[i].push_back(k);
      end else if (!lvl && prev && !fell[i]) begin
        fell[i]      = 1'b1;
        last_fall[i] = k;
      end
    end
    prev = lvl;
  endtask

  // Expected outputs right after edge e.
  task automatic model_observe(input int e);
    for (int i = 0; i < 2; i++) begin
      if (in_rst) begin
        e_v[i] = 1'b0;
        e_s[i] = 1'b0;
        e_c[i] = 0;
        e_p[i] = 0;
      end else begin
        while (rq[i].size() >= 2 && rq[i][1] <= e - lat_of(i)) void'(rq[i].pop_front());
        e_v[i] = 1'b0;
        if (evq[i].size() > 0 && evq[i][0].t == e) begin
          e_v[i] = 1'b1;
          e_c[i] = evq[i][0].c;
          e_p[i] = evq[i][0].p;
          e_s[i] = 1'b0;
          void'(evq[i].pop_front());
        end
        if (e - lat_of(i) - rq[i][0] >= max_of(i)) e_s[i] = 1'b1;
      end
    end
  endtask

  // Drive one cycle, then sample on the following falling edge.
  task automatic step(input logic lvl, input logic rst_lvl);
    reset  = rst_lvl;
    pwm_in = lvl;
    model_drive(lvl, rst_lvl, ecount + 1);
    @(posedge clk);
    @(negedge clk);
    model_observe(ecount);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    for (int c = 0; c < 12; c++) begin
      step(1'($urandom_range(0, 1)), 1'b0);
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (o_v[i] !== 1'b0 || o_s[i] !== 1'b0 || o_c[i] !== 16'd0 || o_p[i] !== 16'd0) begin
          miscompares++;
          $display("FAIL reset dut%0d e=%0d: got v=%0b s=%0b c=%0d p=%0d, want all 0",
                   i, ecount, o_v[i], o_s[i], o_c[i], o_p[i]);
        end
      end
    end
  endtask

  task automatic test_basico;
    int nval = 0;
    for (int c = 0; c < 200; c++) begin
      step((c % 40) < 10, 1'b1);
      if (valido16 === 1'b1) nval++;
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (o_v[i] !== e_v[i] || o_s[i] !== e_s[i] || o_c[i] !== e_c[i] || o_p[i] !== e_p[i]) begin
          miscompares++;
          $display("FAIL basico dut%0d e=%0d: got v=%0b s=%0b c=%0d p=%0d, want v=%0b s=%0b c=%0d p=%0d",
                   i, ecount, o_v[i], o_s[i], o_c[i], o_p[i], e_v[i], e_s[i], e_c[i], e_p[i]);
        end
      end
    end
    vectors++;
    if (nval !== 4 || ciclo16 !== 16'd10 || periodo16 !== 16'd40) begin
      miscompares++;
      $display("FAIL basico_total: got pulses=%0d c=%0d p=%0d, want pulses=4 c=10 p=40",
               nval, ciclo16, periodo16);
    end
  endtask

  task automatic test_generador;
    for (int seg = 0; seg < 6; seg++) begin
      int per = $urandom_range(8, 64);
      int hi  = $urandom_range(1, per - 1);
      for (int c = 0; c < 4 * per; c++) begin
        step((c % per) < hi, 1'b1);
        for (int i = 0; i < 2; i++) begin
          vectors++;
          if (o_v[i] !== e_v[i] || o_s[i] !== e_s[i] || o_c[i] !== e_c[i] || o_p[i] !== e_p[i]) begin
            miscompares++;
            $display("FAIL generador dut%0d e=%0d: got v=%0b s=%0b c=%0d p=%0d, want v=%0b s=%0b c=%0d p=%0d",
                     i, ecount, o_v[i], o_s[i], o_c[i], o_p[i], e_v[i], e_s[i], e_c[i], e_p[i]);
          end
        end
      end
      vectors++;
      if (o_c[0] !== 16'(hi) || o_p[0] !== 16'(per)) begin
        miscompares++;
        $display("FAIL generador_seg%0d: got c=%0d p=%0d, want c=%0d p=%0d",
                 seg, o_c[0], o_p[0], hi, per);
      end
    end
  endtask

  task automatic test_sin_senal;
    int k0    = ecount + 1;
    int t_sin = -1;
    for (int c = 0; c < 300 + 24; c++) begin
      step((c < 300) ? 1'b1 : ((c - 300) % 8) < 4, 1'b1);
      if (t_sin < 0 && sin8 === 1'b1) t_sin = ecount;
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (o_v[i] !== e_v[i] || o_s[i] !== e_s[i] || o_c[i] !== e_c[i] || o_p[i] !== e_p[i]) begin
          miscompares++;
          $display("FAIL sin_senal dut%0d e=%0d: got v=%0b s=%0b c=%0d p=%0d, want v=%0b s=%0b c=%0d p=%0d",
                   i, ecount, o_v[i], o_s[i], o_c[i], o_p[i], e_v[i], e_s[i], e_c[i], e_p[i]);
        end
      end
    end
    vectors++;
    if (t_sin !== k0 + 3 + 255) begin
      miscompares++;
      $display("FAIL sin_senal_timing: got edge %0d, want edge %0d", t_sin, k0 + 3 + 255);
    end
    vectors++;
    if (sin8 !== 1'b0 || ciclo8 !== 8'd4 || periodo8 !== 8'd8) begin
      miscompares++;
      $display("FAIL sin_senal_restart: got s=%0b c=%0d p=%0d, want s=0 c=4 p=8",
               sin8, ciclo8, periodo8);
    end
  endtask

  task automatic test_minimo;
    int nval = 0;
    for (int c = 0; c < 44; c++) begin
      step((c < 40) ? (c % 2 == 0) : 1'b0, 1'b1);
      if (valido16 === 1'b1) nval++;
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (o_v[i] !== e_v[i] || o_s[i] !== e_s[i] || o_c[i] !== e_c[i] || o_p[i] !== e_p[i]) begin
          miscompares++;
          $display("FAIL minimo dut%0d e=%0d: got v=%0b s=%0b c=%0d p=%0d, want v=%0b s=%0b c=%0d p=%0d",
                   i, ecount, o_v[i], o_s[i], o_c[i], o_p[i], e_v[i], e_s[i], e_c[i], e_p[i]);
        end
      end
    end
    vectors++;
    if (nval !== 20 || ciclo16 !== 16'd1 || periodo16 !== 16'd2 || ciclo8 !== 8'd1 || periodo8 !== 8'd2) begin
      miscompares++;
      $display("FAIL minimo_total: got pulses=%0d c16=%0d p16=%0d c8=%0d p8=%0d, want 20 1 2 1 2",
               nval, ciclo16, periodo16, ciclo8, periodo8);
    end
  endtask

  task automatic test_reset_medio;
    int nval = 0;
    // 3 clean periods of 6/16, then a high phase cut by a 3-cycle reset,
    // release while the line is low, then 3 more clean periods.
    for (int c = 0; c < 48 + 6 + 10 + 48; c++) begin
      logic lvl;
      logic rst_lvl;
      int   q = (c < 48) ? c : ((c < 64) ? c - 48 : c - 64);
      lvl     = (q % 16) < 6;
      rst_lvl = !(c >= 51 && c < 54);
      step(lvl, rst_lvl);
      if (c >= 54 && valido16 === 1'b1) nval++;
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (o_v[i] !== e_v[i] || o_s[i] !== e_s[i] || o_c[i] !== e_c[i] || o_p[i] !== e_p[i]) begin
          miscompares++;
          $display("FAIL reset_medio dut%0d e=%0d: got v=%0b s=%0b c=%0d p=%0d, want v=%0b s=%0b c=%0d p=%0d",
                   i, ecount, o_v[i], o_s[i], o_c[i], o_p[i], e_v[i], e_s[i], e_c[i], e_p[i]);
        end
      end
    end
    vectors++;
    if (nval !== 2 || ciclo16 !== 16'd6 || periodo16 !== 16'd16 || ciclo8 !== 8'd6 || periodo8 !== 8'd16) begin
      miscompares++;
      $display("FAIL reset_medio_total: got pulses=%0d c16=%0d p16=%0d c8=%0d p8=%0d, want 2 6 16 6 16",
               nval, ciclo16, periodo16, ciclo8, periodo8);
    end
  endtask

  task automatic test_limite;
    for (int seg = 0; seg < 2; seg++) begin
      int per = 255 + seg;
      for (int c = 0; c < 3 * per; c++) begin
        step((c % per) < 100, 1'b1);
        for (int i = 0; i < 2; i++) begin
          vectors++;
          if (o_v[i] !== e_v[i] || o_s[i] !== e_s[i] || o_c[i] !== e_c[i] || o_p[i] !== e_p[i]) begin
            miscompares++;
            $display("FAIL limite dut%0d e=%0d: got v=%0b s=%0b c=%0d p=%0d, want v=%0b s=%0b c=%0d p=%0d",
                     i, ecount, o_v[i], o_s[i], o_c[i], o_p[i], e_v[i], e_s[i], e_c[i], e_p[i]);
          end
        end
      end
      vectors++;
      if (sin8 !== 1'(seg) || periodo8 !== 8'd255 || ciclo8 !== 8'd100 || periodo16 !== 16'(per)) begin
        miscompares++;
        $display("FAIL limite_seg%0d: got s8=%0b p8=%0d c8=%0d p16=%0d, want s8=%0d p8=255 c8=100 p16=%0d",
                 seg, sin8, periodo8, ciclo8, periodo16, seg, per);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basico;
    test_generador;
    test_sin_senal;
    test_minimo;
    test_reset_medio;
    test_limite;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
